data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MEM stage of the pipelined MIPS datapath and a slow main memory. It produces the `MemReady` signal that the hazard unit consumes: the pipeline stalls while a miss refill or a write-through is outstanding. Main memory is reached through a single-outstanding request/acknowledge handshake.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/dcache_store.sv | 51 +++++
 rtl/data_cache.sv | 154 +++++++++++++++
 tb/tb_data_cache.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data cache: FSM state encoding and default geometry.
package mips_mem_pkg;

  localparam int DEF_LINES  = 64;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    DONE   = 2'd3
  } cache_state_t;

  // Statistics counters are free-running and wrap from 0xFFFF back to 0.
  function automatic logic [15:0] cnt_inc(input logic [15:0] cnt);
    return cnt + 16'd1;
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays of the direct-mapped cache: asynchronous read port,
// synchronous write port with separate fill (allocate) and update (data only) enables.
module dcache_store
  import mips_mem_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int TAG_W  = 24,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              fill_en,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [DATA_W-1:0] data_r [LINES];

  // Valid bits: cleared by reset, set by a refill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
    end else if (fill_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; valid gates their use
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end else if (upd_en) begin
      data_r[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a single-outstanding
// main-memory handshake; mem_ready feeds the pipeline hazard unit.
module data_cache
  import mips_mem_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mm_req,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic [DATA_W-1:0] mm_rdata,
  input  logic              mm_ack,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  cache_state_t      state_r;
  logic [DATA_W-1:0] rdata_r;
  logic              wr_hit_r;

  logic [IDX_W-1:0]  live_idx_s;
  logic [TAG_W-1:0]  live_tag_s;
  logic              line_valid_s;
  logic [TAG_W-1:0]  line_tag_s;
  logic [DATA_W-1:0] line_data_s;
  logic              hit_s;
  logic              fill_en_s;
  logic              upd_en_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [ADDR_W-1:0] aligned_addr_s;
  logic              unused_s;

  assign live_idx_s     = addr[IDX_W+1:2];
  assign live_tag_s     = addr[ADDR_W-1:IDX_W+2];
  assign aligned_addr_s = {addr[ADDR_W-1:2], 2'b00};
  assign hit_s          = line_valid_s && (line_tag_s == live_tag_s);
  assign unused_s       = ^addr[1:0];

  // mm_addr doubles as the latched request address while a transfer is outstanding
  assign fill_en_s = (state_r == RD_REQ) && mm_ack;
  assign upd_en_s  = (state_r == WR_REQ) && mm_ack && wr_hit_r;
  assign wr_data_s = fill_en_s ? mm_rdata : mm_wdata;

  dcache_store #(
    .LINES  (LINES),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (live_idx_s),
    .rd_valid (line_valid_s),
    .rd_tag   (line_tag_s),
    .rd_data  (line_data_s),
    .fill_en  (fill_en_s),
    .upd_en   (upd_en_s),
    .wr_idx   (mm_addr[IDX_W+1:2]),
    .wr_tag   (mm_addr[ADDR_W-1:IDX_W+2]),
    .wr_data  (wr_data_s)
  );

  // Pipeline-facing handshake: hits complete in the same cycle
  always_comb begin
    mem_ready = 1'b1;
    rdata     = '0;
    case (state_r)
      IDLE: begin
        if (mem_write) begin
          mem_ready = 1'b0;
        end else if (mem_read) begin
          if (hit_s) begin
            rdata = line_data_s;
          end else begin
            mem_ready = 1'b0;
          end
        end else begin
          mem_ready = 1'b1;
        end
      end
      RD_REQ, WR_REQ: mem_ready = 1'b0;
      DONE:           rdata     = rdata_r;
      default:        mem_ready = 1'b1;
    endcase
  end

  // Controller FSM with registered memory-side outputs and statistics counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      mm_req     <= 1'b0;
      mm_we      <= 1'b0;
      mm_addr    <= '0;
      mm_wdata   <= '0;
      rdata_r    <= '0;
      wr_hit_r   <= 1'b0;
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_write) begin
            mm_req   <= 1'b1;
            mm_we    <= 1'b1;
            mm_addr  <= aligned_addr_s;
            mm_wdata <= wdata;
            wr_hit_r <= hit_s;
            state_r  <= WR_REQ;
          end else if (mem_read) begin
            if (hit_s) begin
              hit_count <= cnt_inc(hit_count);
            end else begin
              miss_count <= cnt_inc(miss_count);
              mm_req     <= 1'b1;
              mm_we      <= 1'b0;
              mm_addr    <= aligned_addr_s;
              state_r    <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (mm_ack) begin
            mm_req  <= 1'b0;
            rdata_r <= mm_rdata;
            state_r <= DONE;
          end
        end
        WR_REQ: begin
          if (mm_ack) begin
            mm_req  <= 1'b0;
            rdata_r <= '0;
            state_r <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized traffic against
// an array-based cache and main-memory model.
module tb_data_cache;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        mm_req;
  logic        mm_we;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks_total;
  int checks_passed;

  // Reference model: 64 one-word lines plus a sparse main memory
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] mem     [logic [29:0]];
  logic [15:0] m_hits;
  logic [15:0] m_miss;

  data_cache dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .rdata      (rdata),
    .mem_ready  (mem_ready),
    .mm_req     (mm_req),
    .mm_we      (mm_we),
    .mm_addr    (mm_addr),
    .mm_wdata   (mm_wdata),
    .mm_rdata   (mm_rdata),
    .mm_ack     (mm_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits = 16'd0;
    m_miss = 16'd0;
  endtask

  // One pipeline access issued in IDLE; k = cycles from mm_req rising to mm_ack
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input int k);
    int          idx;
    logic [23:0] tg;
    logic [29:0] wa;
    bit          hit;
    logic [31:0] mv;
    logic [31:0] exp_rd;
    idx = int'(a[7:2]);
    tg  = a[31:8];
    wa  = a[31:2];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    @(negedge clk);
    addr = a; wdata = wd; mem_read = rd; mem_write = wr;
    #1;
    if (!rd && !wr) begin
      check("idle_ready", {31'd0, mem_ready}, 32'd1);
      check("idle_rdata", rdata, 32'd0);
      @(posedge clk);
      return;
    end
    if (!wr && hit) begin
      check("hit_ready", {31'd0, mem_ready}, 32'd1);
      check("hit_rdata", rdata, m_data[idx]);
      check("hit_no_req", {31'd0, mm_req}, 32'd0);
      m_hits = m_hits + 16'd1;
      @(posedge clk);
      #1;
      check("hit_count", {16'd0, hit_count}, {16'd0, m_hits});
      check("miss_count", {16'd0, miss_count}, {16'd0, m_miss});
      return;
    end
    check("req_ready_low", {31'd0, mem_ready}, 32'd0);
    if (!wr) m_miss = m_miss + 16'd1;
    if (!mem.exists(wa)) mem[wa] = $urandom;
    mv = mem[wa];
    @(posedge clk);
    for (int j = 0; j <= k; j++) begin
      @(negedge clk);
      addr      = $urandom;
      wdata     = $urandom;
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = 1'($urandom_range(0, 1));
      mm_rdata  = $urandom;
      #1;
      check("busy_ready_low", {31'd0, mem_ready}, 32'd0);
      check("busy_mm_req", {31'd0, mm_req}, 32'd1);
      check("busy_mm_we", {31'd0, mm_we}, {31'd0, wr});
      check("busy_mm_addr", mm_addr, {a[31:2], 2'b00});
      if (wr) check("busy_mm_wdata", mm_wdata, wd);
      if (j == k) begin
        mm_ack   = 1'b1;
        mm_rdata = mv;
      end
    end
    @(posedge clk);
    if (wr) begin
      mem[wa] = wd;
      if (hit) m_data[idx] = wd;
      exp_rd = 32'd0;
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = mv;
      exp_rd       = mv;
    end
    @(negedge clk);
    mm_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mm_rdata = $urandom;
    #1;
    check("done_ready", {31'd0, mem_ready}, 32'd1);
    check("done_rdata", rdata, exp_rd);
    check("done_req_low", {31'd0, mm_req}, 32'd0);
    check("hit_count", {16'd0, hit_count}, {16'd0, m_hits});
    check("miss_count", {16'd0, miss_count}, {16'd0, m_miss});
    @(posedge clk);
  endtask

  initial begin
    checks_total = 0;
    checks_passed = 0;
    reset = 1'b0; addr = 32'd0; wdata = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
    mm_rdata = 32'd0; mm_ack = 1'b0;
    model_reset();
    #12;
    check("rst_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mm_req", {31'd0, mm_req}, 32'd0);
    check("rst_mm_we", {31'd0, mm_we}, 32'd0);
    check("rst_mm_addr", mm_addr, 32'd0);
    check("rst_mm_wdata", mm_wdata, 32'd0);
    check("rst_hits", {16'd0, hit_count}, 32'd0);
    check("rst_misses", {16'd0, miss_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed scenarios
    mem[30'h40] = 32'hDEADBEEF;
    access(1'b1, 1'b0, 32'h100, 32'd0, 1);
    access(1'b1, 1'b0, 32'h100, 32'd0, 0);
    access(1'b0, 1'b1, 32'h100, 32'hCAFE0001, 2);
    access(1'b1, 1'b0, 32'h100, 32'd0, 0);
    access(1'b0, 1'b1, 32'h204, 32'h12345678, 0);
    access(1'b1, 1'b0, 32'h204, 32'd0, 3);
    access(1'b1, 1'b0, 32'h100 + 32'd256, 32'd0, 1);
    access(1'b1, 1'b0, 32'h100, 32'd0, 0);
    access(1'b1, 1'b1, 32'h100, 32'h0BADF00D, 1);
    access(1'b1, 1'b0, 32'h100, 32'd0, 0);

    // Reset in the middle of a refill
    @(negedge clk);
    addr = 32'h3C0; mem_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    check("midmiss_req", {31'd0, mm_req}, 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_mm_req", {31'd0, mm_req}, 32'd0);
    check("arst_ready", {31'd0, mem_ready}, 32'd1);
    check("arst_hits", {16'd0, hit_count}, 32'd0);
    check("arst_misses", {16'd0, miss_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1; mm_ack = 1'b1; mm_rdata = 32'h55AA55AA;
    @(negedge clk);
    mm_ack = 1'b0;
    #1;
    check("late_ack_req", {31'd0, mm_req}, 32'd0);
    check("late_ack_ready", {31'd0, mem_ready}, 32'd1);
    check("late_ack_rdata", rdata, 32'd0);
    access(1'b1, 1'b0, 32'h100, 32'd0, 1);

    // Randomized traffic over a small address pool to force hits and conflicts
    for (int n = 0; n < 400; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 5));
      a  = {22'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      case (op)
        0:       access(1'b0, 1'b0, a, 32'd0, 0);
        1:       access(1'b0, 1'b1, a, $urandom, int'($urandom_range(0, 3)));
        2:       access(1'b1, 1'b1, a, $urandom, int'($urandom_range(0, 3)));
        default: access(1'b1, 1'b0, a, 32'd0, int'($urandom_range(0, 3)));
      endcase
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
